// File: rtl/dev_rx_cmd_split_if.sv
// Request and FIFO-write signal bundle for dev_rx_cmd_split.
// The slave modport is the splitter; the master modport is the request source / FIFO side.
interface dev_rx_cmd_split_if #(
  parameter int unsigned CmdWidth = 30
);
  logic                req_valid;
  logic                req_ready;
  logic [45:0]         req_addr;
  logic [12:0]         req_len_dw;
  logic                fifo_wr_en;
  logic [CmdWidth-1:0] fifo_wr_data;
  logic                fifo_full_n;

  modport slave (
    input  req_valid, req_addr, req_len_dw, fifo_full_n,
    output req_ready, fifo_wr_en, fifo_wr_data
  );

  modport master (
    output req_valid, req_addr, req_len_dw, fifo_full_n,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/dev_rx_cmd_split.sv
// Splits DMA RX read requests into P_MRRS_DW-aligned chunks, two command words per chunk.
// Optional statistics counters are enabled with the DEV_RX_CMD_SPLIT_STAT_EN macro.
module dev_rx_cmd_split #(
  parameter int unsigned P_MRRS_DW   = 128,
  parameter int unsigned P_CMD_WIDTH = 30
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst_n,
  dev_rx_cmd_split_if.slave        bus,
`ifdef DEV_RX_CMD_SPLIT_STAT_EN
  output logic [15:0]              stat_req_cnt_o,
  output logic [15:0]              stat_chunk_cnt_o,
`endif
  output logic                     busy_o
);

  localparam int unsigned OffW = $clog2(P_MRRS_DW);

  typedef enum logic [1:0] {StIdle, StW0, StW1} state_e;

  state_e      state_q, state_d;
  logic [45:0] cur_addr_q, cur_addr_d;
  logic [12:0] rem_q, rem_d;

  logic [12:0]            len_clamped;
  logic [OffW:0]          bnd;
  logic [12:0]            bnd_ext;
  logic [12:0]            chunk;
  logic [6:0]             len_field;
  logic [P_CMD_WIDTH-1:0] cmd_word;
  logic                   accept_nz;
  logic                   w1_write;

  assign len_clamped = (bus.req_len_dw > 13'd4096) ? 13'd4096 : bus.req_len_dw;

  // Distance to the next aligned boundary; always 1..P_MRRS_DW.
  assign bnd       = (OffW + 1)'(P_MRRS_DW) - {1'b0, cur_addr_q[OffW-1:0]};
  assign bnd_ext   = 13'(bnd);
  assign chunk     = (rem_q < bnd_ext) ? rem_q : bnd_ext;
  assign len_field = 7'(chunk - 13'd1);

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    rem_d         = rem_q;
    cmd_word      = '0;
    bus.req_ready = 1'b0;
    bus.fifo_wr_en = 1'b0;
    accept_nz     = 1'b0;
    w1_write      = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          cur_addr_d = bus.req_addr;
          rem_d      = len_clamped;
          if (len_clamped != 13'd0) begin
            state_d   = StW0;
            accept_nz = 1'b1;
          end
        end
      end
      StW0: begin
        bus.fifo_wr_en = bus.fifo_full_n;
        cmd_word       = {1'b1, len_field, cur_addr_q[45:24]};
        if (bus.fifo_full_n) state_d = StW1;
      end
      StW1: begin
        bus.fifo_wr_en = bus.fifo_full_n;
        cmd_word       = {1'b0, 5'b0, cur_addr_q[23:0]};
        if (bus.fifo_full_n) begin
          w1_write   = 1'b1;
          cur_addr_d = cur_addr_q + 46'(chunk);
          rem_d      = rem_q - chunk;
          state_d    = (rem_q == chunk) ? StIdle : StW0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.fifo_wr_data = cmd_word;
  assign busy_o           = (state_q != StIdle);

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q    <= StIdle;
      cur_addr_q <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
    end
  end

`ifdef DEV_RX_CMD_SPLIT_STAT_EN
  logic [15:0] req_cnt_q, req_cnt_d;
  logic [15:0] chunk_cnt_q, chunk_cnt_d;

  always_comb begin
    req_cnt_d   = req_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    if (accept_nz && (req_cnt_q != 16'hFFFF)) req_cnt_d = req_cnt_q + 16'd1;
    if (w1_write && (chunk_cnt_q != 16'hFFFF)) chunk_cnt_d = chunk_cnt_q + 16'd1;
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      req_cnt_q   <= '0;
      chunk_cnt_q <= '0;
    end else begin
      req_cnt_q   <= req_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
    end
  end

  assign stat_req_cnt_o   = req_cnt_q;
  assign stat_chunk_cnt_o = chunk_cnt_q;
`else
  logic unused_stat;
  assign unused_stat = accept_nz ^ w1_write;
`endif

endmodule

// File: tb/tb_dev_rx_cmd_split.sv
// Randomized and directed bench for dev_rx_cmd_split against a queue-based chunking model.
module tb_dev_rx_cmd_split;

  localparam int Mrrs = 128;

  logic wr_clk   = 1'b0;
  logic wr_rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   rand_bp = 1'b0;

  logic [29:0] obs_q[$];
  int          obs_cyc[$];
  logic [29:0] exp_q[$];
  int          model_req   = 0;
  int          model_chunk = 0;

  dev_rx_cmd_split_if bus ();

`ifdef DEV_RX_CMD_SPLIT_STAT_EN
  logic [15:0] stat_req_cnt;
  logic [15:0] stat_chunk_cnt;
`endif

  dev_rx_cmd_split #(
    .P_MRRS_DW   (Mrrs),
    .P_CMD_WIDTH (30)
  ) dut (
    .wr_clk           (wr_clk),
    .wr_rst_n         (wr_rst_n),
    .bus              (bus.slave),
`ifdef DEV_RX_CMD_SPLIT_STAT_EN
    .stat_req_cnt_o   (stat_req_cnt),
    .stat_chunk_cnt_o (stat_chunk_cnt),
`endif
    .busy_o           (busy)
  );

  always #5 wr_clk = ~wr_clk;

  // Word monitor, sampled mid-cycle.
  always @(negedge wr_clk) begin
    #2;
    cyc++;
    if (bus.fifo_wr_en) begin
      checks++;
      if (!bus.fifo_full_n) begin
        errors++;
        $display("FAIL wr_en_while_full: wr_en=%0b full_n=%0b required wr_en=0", bus.fifo_wr_en,
                 bus.fifo_full_n);
      end else begin
        obs_q.push_back(bus.fifo_wr_data);
        obs_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge wr_clk) begin
    if (rand_bp) bus.fifo_full_n = ($urandom_range(0, 3) != 0);
  end

  // Reference: cut [addr, addr+len) at Mrrs-aligned boundaries, two words per piece.
  task automatic build_exp(input logic [45:0] addr, input int len);
    logic [45:0] a;
    int rem, off, ch;
    a   = addr;
    rem = (len > 4096) ? 4096 : len;
    if (rem > 0) model_req++;
    while (rem > 0) begin
      off = int'(a % 46'(Mrrs));
      ch  = Mrrs - off;
      if (rem < ch) ch = rem;
      exp_q.push_back({1'b1, 7'(ch - 1), a[45:24]});
      exp_q.push_back({6'b0, a[23:0]});
      model_chunk++;
      a   = a + 46'(ch);
      rem = rem - ch;
    end
  endtask

  task automatic clear_q();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  // Presents one request; returns at the negedge just after the accept edge.
  task automatic send_req(input logic [45:0] addr, input logic [12:0] len);
    @(negedge wr_clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_len_dw = len;
    @(negedge wr_clk);
    bus.req_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    #1;
    while (!(bus.req_ready && !busy) && n < budget) begin
      @(negedge wr_clk);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    wr_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.fifo_wr_en, bus.fifo_wr_data, busy} !== {1'b1, 1'b0, 30'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%0b wr_en=%0b data=%h busy=%0b required 1 0 0 0",
               bus.req_ready, bus.fifo_wr_en, bus.fifo_wr_data, busy);
    end
    repeat (2) @(negedge wr_clk);
    wr_rst_n = 1'b1;
  endtask

  task automatic test_single();
    clear_q();
    bus.fifo_full_n = 1'b1;
    send_req(46'h400, 13'd128);
    #1;
    checks++;
    if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 30'h3FC00000) begin
      errors++;
      $display("FAIL single_w0: wr_en=%0b data=%h required 1 3fc00000", bus.fifo_wr_en,
               bus.fifo_wr_data);
    end
    @(negedge wr_clk);
    #1;
    checks++;
    if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 30'h400 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_w1: wr_en=%0b data=%h ready=%0b required 1 400 0", bus.fifo_wr_en,
               bus.fifo_wr_data, bus.req_ready);
    end
    @(negedge wr_clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_back: ready=%0b busy=%0b wr_en=%0b required 1 0 0",
               bus.req_ready, busy, bus.fifo_wr_en);
    end
    #2;
    checks++;
    if (obs_q.size() != 2 || obs_cyc[1] - obs_cyc[0] != 1) begin
      errors++;
      $display("FAIL single_words: count=%0d required 2 on consecutive cycles", obs_q.size());
    end
  endtask

  task automatic test_boundary();
    logic [29:0] req[4];
    req = '{30'h2FC00000, 30'h7C0, 30'h2FC00000, 30'h800};
    clear_q();
    send_req(46'h7C0, 13'd128);
    wait_idle(50, "boundary");
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL boundary_count: got %0d words required 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i] !== req[i]) begin
          errors++;
          $display("FAIL boundary_word%0d: got %h required %h", i, obs_q[i], req[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    bus.fifo_full_n = 1'b1;
    send_req(46'h400, 13'd128);
    @(negedge wr_clk);
    bus.fifo_full_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.fifo_wr_en !== 1'b0 || bus.fifo_wr_data !== 30'h400) begin
        errors++;
        $display("FAIL bp_stall%0d: wr_en=%0b data=%h required 0 400", i, bus.fifo_wr_en,
                 bus.fifo_wr_data);
      end
      @(negedge wr_clk);
    end
    bus.fifo_full_n = 1'b1;
    #1;
    checks++;
    if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 30'h400) begin
      errors++;
      $display("FAIL bp_release: wr_en=%0b data=%h required 1 400", bus.fifo_wr_en,
               bus.fifo_wr_data);
    end
    wait_idle(20, "bp");
    repeat (2) @(negedge wr_clk);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL bp_write_count: got %0d writes required 2", obs_q.size());
    end
  endtask

  task automatic test_zero();
    clear_q();
    send_req(46'h123, 13'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL zero_len_c%0d: ready=%0b busy=%0b wr_en=%0b required 1 0 0", i,
                 bus.req_ready, busy, bus.fifo_wr_en);
      end
      @(negedge wr_clk);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL zero_len_writes: got %0d required 0", obs_q.size());
    end
  endtask

  task automatic test_max_wrap();
    logic [45:0] addrs[2];
    addrs = '{46'h0, 46'h3FFF_FFFF_FFC0};
    for (int r = 0; r < 2; r++) begin
      clear_q();
      build_exp(addrs[r], (r == 0) ? 4096 : 128);
      send_req(addrs[r], (r == 0) ? 13'd4096 : 13'd128);
      wait_idle(200, "maxwrap");
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL maxwrap%0d_count: got %0d required %0d", r, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL maxwrap%0d_word%0d: got %h required %h", r, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_req(46'h1000, 13'd4);
    wait_idle(10, "b2b_first");
    bus.req_valid  = 1'b1;
    bus.req_addr   = 46'h2000;
    bus.req_len_dw = 13'd4;
    @(negedge wr_clk);
    bus.req_valid  = 1'b0;
    wait_idle(10, "b2b_second");
    checks++;
    if (obs_q.size() != 4 || obs_cyc[2] - obs_cyc[1] != 2) begin
      errors++;
      $display("FAIL b2b_gap: words=%0d gap=%0d required 4 words gap 2", obs_q.size(),
               (obs_q.size() == 4) ? obs_cyc[2] - obs_cyc[1] : -1);
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    send_req(46'h0, 13'd256);
    @(negedge wr_clk);
    wr_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.fifo_wr_en, bus.fifo_wr_data, busy} !== {1'b1, 1'b0, 30'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_outputs: ready=%0b wr_en=%0b data=%h busy=%0b required 1 0 0 0",
               bus.req_ready, bus.fifo_wr_en, bus.fifo_wr_data, busy);
    end
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    model_req   = 0;
    model_chunk = 0;
    clear_q();
    build_exp(46'h40, 13'd8);
    send_req(46'h40, 13'd8);
    wait_idle(10, "reset_mid");
    checks++;
    if (obs_q.size() == 0 || obs_q[0][29] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_first_word: words=%0d required first word with bit29=1",
               obs_q.size());
    end
  endtask

  task automatic test_random();
    logic [45:0] addr;
    int len, sel;
    rand_bp = 1'b1;
    for (int r = 0; r < 25; r++) begin
      clear_q();
      addr = 46'({$urandom, $urandom});
      sel  = $urandom_range(0, 9);
      len  = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(4097, 8191) : $urandom_range(1, 300);
      build_exp(addr, len);
      send_req(addr, 13'(len));
      wait_idle(400, "random");
      @(negedge wr_clk);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL random%0d_count: addr=%h len=%0d got %0d words required %0d", r, addr,
                 len, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random%0d_word%0d: got %h required %h", r, i, obs_q[i], exp_q[i]);
        end
      end
    end
    rand_bp = 1'b0;
    bus.fifo_full_n = 1'b1;
  endtask

`ifdef DEV_RX_CMD_SPLIT_STAT_EN
  task automatic test_stats();
    checks++;
    if (stat_req_cnt !== 16'(model_req) || stat_chunk_cnt !== 16'(model_chunk)) begin
      errors++;
      $display("FAIL stats: req=%0d chunk=%0d required %0d %0d", stat_req_cnt, stat_chunk_cnt,
               model_req, model_chunk);
    end
  endtask
`endif

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_len_dw  = '0;
    bus.fifo_full_n = 1'b1;
    test_reset();
    test_single();
    test_boundary();
    test_backpressure();
    test_zero();
    test_max_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DEV_RX_CMD_SPLIT_STAT_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
